// File: rtl/servo_pkg.sv
// Shared parameters, state encoding and command-to-pulse-width mapping for the servo PWM stage.
package servo_pkg;

  localparam int unsigned SERVO_WIDTH     = 12;
  localparam int unsigned SERVO_CLK_DIV   = 50;
  localparam int unsigned SERVO_PERIOD_US = 20000;
  localparam int unsigned SERVO_CENTER_US = 1500;
  localparam int unsigned SERVO_MIN_US    = 1000;
  localparam int unsigned SERVO_MAX_US    = 2000;
  localparam int unsigned SERVO_SHIFT     = 2;

  localparam int unsigned US_W      = 15;
  localparam int unsigned PW_W      = 16;
  localparam int unsigned CMD_EXT_W = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HIGH = 2'b01,
    ST_LOW  = 2'b10
  } servo_state_e;

  // center + (cmd >>> shift), evaluated signed at 17 bits, clamped to [min_us, max_us]
  function automatic logic [PW_W-1:0] sat_width(
    input logic signed [CMD_EXT_W-1:0] cmd,
    input int unsigned                 shift,
    input int unsigned                 center_us,
    input int unsigned                 min_us,
    input int unsigned                 max_us
  );
    logic signed [CMD_EXT_W-1:0] mapped;
    mapped = $signed({1'b0, PW_W'(center_us)}) + (cmd >>> shift);
    if (mapped < $signed({1'b0, PW_W'(min_us)})) return PW_W'(min_us);
    if (mapped > $signed({1'b0, PW_W'(max_us)})) return PW_W'(max_us);
    return mapped[PW_W-1:0];
  endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// Microsecond timebase: clock prescaler feeding a wrapping per-period microsecond counter.
module servo_tick_gen import servo_pkg::*; #(
  parameter int unsigned CLK_DIV   = SERVO_CLK_DIV,
  parameter int unsigned PERIOD_US = SERVO_PERIOD_US
) (
  input  logic            clk_i,
  input  logic            reset,
  input  logic            clear_i,
  output logic            tick_c,
  output logic            boundary_c,
  output logic [US_W-1:0] us_cnt_o
);

  localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [US_W-1:0]  us_q, us_d;

  always_comb begin
    pre_d      = pre_q;
    us_d       = us_q;
    tick_c     = (pre_q == PRE_W'(CLK_DIV - 1));
    boundary_c = tick_c && (us_q == US_W'(PERIOD_US - 1));
    if (clear_i) begin
      pre_d = '0;
      us_d  = '0;
    end else if (tick_c) begin
      pre_d = '0;
      us_d  = boundary_c ? '0 : us_q + US_W'(1);
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      pre_q <= '0;
      us_q  <= '0;
    end else begin
      pre_q <= pre_d;
      us_q  <= us_d;
    end
  end

  assign us_cnt_o = us_q;

endmodule

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: captures PID commands into a shadow width and emits glitch-free periodic pulses.
module servo_pwm_gen import servo_pkg::*; #(
  parameter int unsigned WIDTH     = SERVO_WIDTH,
  parameter int unsigned CLK_DIV   = SERVO_CLK_DIV,
  parameter int unsigned PERIOD_US = SERVO_PERIOD_US,
  parameter int unsigned CENTER_US = SERVO_CENTER_US,
  parameter int unsigned MIN_US    = SERVO_MIN_US,
  parameter int unsigned MAX_US    = SERVO_MAX_US,
  parameter int unsigned SHIFT     = SERVO_SHIFT
) (
  input  logic                    clk_i,
  input  logic                    reset,
  input  logic                    en_i,
  input  logic signed [WIDTH-1:0] servo_i,
  input  logic                    dataf_i,
  output logic                    pwm_o,
  output logic                    ack_o,
  output logic                    period_o,
  output logic [PW_W-1:0]         width_o
);

  servo_state_e state_q, state_d;
  logic pwm_q, pwm_d, ack_q, ack_d, period_q, period_d, dataf_q, dataf_d;
  logic [PW_W-1:0] width_q, width_d, shadow_q, shadow_d, mapped;
  logic signed [CMD_EXT_W-1:0] cmd_ext;
  logic capture, start, clear, tick, boundary;
  logic [US_W-1:0] us_cnt;

  servo_tick_gen #(
    .CLK_DIV   (CLK_DIV),
    .PERIOD_US (PERIOD_US)
  ) u_tick (
    .clk_i      (clk_i),
    .reset      (reset),
    .clear_i    (clear),
    .tick_c     (tick),
    .boundary_c (boundary),
    .us_cnt_o   (us_cnt)
  );

  always_comb begin
    cmd_ext = CMD_EXT_W'(servo_i);
    mapped  = sat_width(cmd_ext, SHIFT, CENTER_US, MIN_US, MAX_US);
  end

  // Next state, shadow capture and period-start width load
  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    shadow_d = shadow_q;
    dataf_d  = dataf_i;
    period_d = 1'b0;
    clear    = 1'b0;
    start    = 1'b0;
    capture  = dataf_i & ~dataf_q;
    ack_d    = capture;
    if (capture) shadow_d = mapped;

    case (state_q)
      ST_IDLE: begin
        clear = 1'b1;
        if (en_i) begin
          start   = 1'b1;
          width_d = shadow_q;
        end
      end
      ST_HIGH: begin
        if (tick && ({1'b0, us_cnt} == width_q - PW_W'(1))) state_d = ST_LOW;
      end
      ST_LOW: begin
        if (boundary) begin
          if (en_i) begin
            start   = 1'b1;
            width_d = capture ? mapped : shadow_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d  = ST_HIGH;
      period_d = 1'b1;
    end
    pwm_d = (state_d == ST_HIGH);
  end

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pwm_q    <= 1'b0;
      ack_q    <= 1'b0;
      period_q <= 1'b0;
      dataf_q  <= 1'b0;
      width_q  <= PW_W'(CENTER_US);
      shadow_q <= PW_W'(CENTER_US);
    end else begin
      state_q  <= state_d;
      pwm_q    <= pwm_d;
      ack_q    <= ack_d;
      period_q <= period_d;
      dataf_q  <= dataf_d;
      width_q  <= width_d;
      shadow_q <= shadow_d;
    end
  end

  assign pwm_o    = pwm_q;
  assign ack_o    = ack_q;
  assign period_o = period_q;
  assign width_o  = width_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Randomized bench for servo_pwm_gen against a period-position reference model (scaled-down timebase).
module tb_servo_pwm_gen;

  localparam int unsigned W    = 8;
  localparam int unsigned CD   = 3;
  localparam int unsigned PER  = 60;
  localparam int unsigned CTR  = 30;
  localparam int unsigned MINV = 20;
  localparam int unsigned MAXV = 40;
  localparam int unsigned SH   = 2;
  localparam int PER_CYC = int'(PER * CD);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic dataf = 1'b0;
  logic signed [W-1:0] servo = '0;
  logic pwm, ack, period;
  logic [15:0] width;

  servo_pwm_gen #(
    .WIDTH     (W),
    .CLK_DIV   (CD),
    .PERIOD_US (PER),
    .CENTER_US (CTR),
    .MIN_US    (MINV),
    .MAX_US    (MAXV),
    .SHIFT     (SH)
  ) dut (
    .clk_i    (clk),
    .reset    (reset),
    .en_i     (en),
    .servo_i  (servo),
    .dataf_i  (dataf),
    .pwm_o    (pwm),
    .ack_o    (ack),
    .period_o (period),
    .width_o  (width)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: position within the running period plus committed/pending widths
  bit m_run, m_prev, exp_pwm, exp_period, exp_ack;
  int m_t, m_width, m_shadow;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_map(input logic signed [W-1:0] s);
    int v;
    v = int'(CTR) + (int'(s) >>> SH);
    if (v < int'(MINV)) v = int'(MINV);
    if (v > int'(MAXV)) v = int'(MAXV);
    return v;
  endfunction

  task automatic model_reset();
    m_run = 0; m_prev = 0; m_t = 0;
    m_width = int'(CTR); m_shadow = int'(CTR);
    exp_pwm = 0; exp_period = 0; exp_ack = 0;
  endtask

  task automatic model_step();
    bit cap, start;
    int mapped;
    cap = dataf && !m_prev;
    mapped = ref_map(servo);
    start = 0;
    if (m_run) begin
      m_t++;
      if (m_t == PER_CYC) begin
        m_t = 0;
        if (en) begin
          start = 1;
          m_width = cap ? mapped : m_shadow;
        end else begin
          m_run = 0;
        end
      end
    end else if (en) begin
      start = 1;
      m_width = m_shadow;
    end
    if (start) begin
      m_run = 1;
      m_t = 0;
    end
    exp_period = start;
    exp_pwm = m_run && (m_t < m_width * int'(CD));
    exp_ack = cap;
    if (cap) m_shadow = mapped;
    m_prev = dataf;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_step();
    else model_reset();
    @(negedge clk);
    check_eq("pwm", 32'(pwm), 32'(exp_pwm));
    check_eq("period", 32'(period), 32'(exp_period));
    check_eq("ack", 32'(ack), 32'(exp_ack));
    check_eq("width", 32'(width), 32'(m_width));
  endtask

  task automatic pulse(input logic signed [W-1:0] v);
    dataf = 1'b1;
    servo = v;
    cycle();
    dataf = 1'b0;
    servo = W'($urandom);
    cycle();
  endtask

  // Bounded wait until the model sits at period position t (within a running period)
  task automatic wait_pos(input int t, input string tag);
    int n;
    n = 0;
    while (!(m_run && m_t == t) && n < 3 * PER_CYC) begin
      cycle();
      n++;
    end
    check_eq(tag, 32'(m_run && m_t == t), 32'd1);
  endtask

  initial begin
    int hold;
    model_reset();
    #1 reset = 1'b0;
    #1;
    check_eq("rst_pwm", 32'(pwm), 32'd0);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_period", 32'(period), 32'd0);
    check_eq("rst_width", 32'(width), 32'(CTR));
    repeat (3) cycle();
    reset = 1'b1;

    en = 1'b1;
    repeat (2 * PER_CYC + 5) cycle();

    pulse(W'(16));
    repeat (PER_CYC + 10) cycle();
    pulse(W'(127));
    repeat (PER_CYC) cycle();
    pulse(-W'(128));
    repeat (PER_CYC) cycle();

    wait_pos(PER_CYC - 1, "wait_boundary");
    dataf = 1'b1;
    servo = -W'(8);
    cycle();
    check_eq("bypass_width", 32'(width), 32'd28);
    dataf = 1'b0;
    repeat (PER_CYC) cycle();

    dataf = 1'b1;
    servo = W'(12);
    repeat (10) cycle();
    dataf = 1'b0;
    repeat (20) cycle();
    pulse(W'(40));
    repeat (7) cycle();
    pulse(-W'(20));
    repeat (PER_CYC + 5) cycle();

    wait_pos(15 * int'(CD), "wait_mid");
    en = 1'b0;
    repeat (2 * PER_CYC) cycle();
    en = 1'b1;
    repeat (PER_CYC + 10) cycle();

    wait_pos(5, "wait_high");
    #2 reset = 1'b0;
    #1;
    check_eq("async_pwm", 32'(pwm), 32'd0);
    check_eq("async_width", 32'(width), 32'(CTR));
    check_eq("async_period", 32'(period), 32'd0);
    cycle();
    reset = 1'b1;
    repeat (PER_CYC + 5) cycle();

    hold = 0;
    for (int i = 0; i < 6000; i++) begin
      if (hold > 0) hold--;
      else dataf = 1'b0;
      if (hold == 0 && $urandom_range(0, 24) == 0) begin
        dataf = 1'b1;
        servo = W'($urandom);
        hold = int'($urandom_range(1, 4));
      end
      if ($urandom_range(0, 499) == 0) en = ~en;
      cycle();
    end
    dataf = 1'b0;
    repeat (10) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/servo_pwm_gen.md
Name: servo_pwm_gen

Overview:
- Stage directly downstream of the PID controller.
- Consumes the signed WIDTH-bit servo command and its one-cycle done strobe (dataf), and maps the command to a clamped pulse width in microseconds.
- Generates the periodic servo PWM waveform.
- New widths are double-buffered and take effect only at period boundaries, so every pulse is glitch-free.

Parameters:
- WIDTH, 12, servo command width (signed, two's complement)
- CLK_DIV, 50, clk_i cycles per microsecond tick (50 MHz clock)
- PERIOD_US, 20000, PWM period in microseconds
- CENTER_US, 1500, pulse width for command 0
- MIN_US, 1000, lower pulse-width clamp
- MAX_US, 2000, upper pulse-width clamp
- SHIFT, 2, arithmetic right shift applied to the command before adding to CENTER_US

Ports:
- clk_i  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- en_i  in  1  output enable
- servo_i  in  WIDTH  signed command from the PID stage
- dataf_i  in  1  command-valid strobe from the PID stage
- pwm_o  out  1  servo PWM output
- ack_o  out  1  one-cycle pulse: command captured into the shadow register
- period_o  out  1  one-cycle pulse at the start of each PWM period
- width_o  out  16  pulse width (us) applied in the current period

Behaviour:
- Reset (reset=0, asynchronous):
  - pwm_o=0, ack_o=0, period_o=0.
  - width_o=CENTER_US; shadow=CENTER_US.
  - Prescaler=0, us counter=0, dataf_d=0, state=IDLE.
  - Reset asserted mid-pulse drops pwm_o immediately.
- Capture:
  - Rising edge of dataf_i is detected as dataf_i & ~dataf_d, with dataf_d registered.
  - On that cycle, mapped = CENTER_US + (servo_i >>> SHIFT), computed signed at 17 bits, then clamped to [MIN_US, MAX_US].
  - shadow <= mapped; ack_o=1 on the next cycle, for exactly one cycle.
  - A held-high dataf_i captures only once.
  - Capture is accepted in every state, including IDLE.
- Timebase:
  - Prescaler counts 0..CLK_DIV-1; tick = (prescaler==CLK_DIV-1).
  - The us counter (15 bits) increments on tick and wraps PERIOD_US-1 -> 0.
  - Boundary = tick & us_cnt==PERIOD_US-1.
- State machine:
  - IDLE:
    - Counters held at 0, pwm_o=0.
    - If en_i=1: next state HIGH, width_o <= shadow, period_o=1 for one cycle.
  - HIGH:
    - pwm_o=1 while us_cnt < width_o.
    - On tick with us_cnt==width_o-1: go to LOW.
  - LOW:
    - pwm_o=0.
    - On boundary with en_i=1: width_o <= shadow, period_o=1, go to HIGH.
    - On boundary with en_i=0: go to IDLE.
- Timing:
  - pwm_o is registered.
  - First rising edge of pwm_o occurs one cycle after the IDLE->HIGH transition cycle.
  - High time = width_o*CLK_DIV clk cycles exactly; period = PERIOD_US*CLK_DIV cycles.
- en_i deassertion mid-period: the current period completes fully; no truncated pulse.
- Capture and boundary in the same cycle: the freshly mapped value bypasses the shadow and is loaded into width_o for the starting period.
- Two captures within one period: the last one wins; each capture still produces its own ack_o.
- Clamp: MIN_US <= width_o <= MAX_US always holds. The parameters must satisfy MAX_US < PERIOD_US, so LOW is never skipped.

Decomposition:
- Shared package servo_pkg:
  - WIDTH, CLK_DIV, PERIOD_US, CENTER_US, MIN_US, MAX_US, SHIFT defaults.
  - State encoding ST_IDLE=2'b00, ST_HIGH=2'b01, ST_LOW=2'b10.
  - Function sat_width() implementing the map/clamp, reusable by the PID bench model.
- One sub-module servo_tick_gen: prescaler plus us counter with wrap; outputs tick, us_cnt and boundary; synchronous clear input used in IDLE.

Test Plan:
- Reset released, en_i=1, no command -> period_o pulse, then pwm_o high for 75000 cycles and low for 925000; width_o=1500.
- servo_i=400, dataf_i pulse -> ack_o after 1 cycle; next period width_o=1600, high 80000 cycles; current period unchanged.
- Clamp cases:
  - servo_i=2047 -> 1500+511=2011 -> width_o=2000.
  - servo_i=-2048 -> 1500-512=988 -> width_o=1000.
- Strobe edge cases:
  - dataf_i pulse on the boundary cycle with servo_i=-200 -> the starting period uses width 1450.
  - dataf_i held high for 10 cycles -> single ack_o.
- en_i dropped 5000 us into a period -> that period completes; no further period_o; pwm_o stays 0.
  - en_i reasserted -> period_o on the next cycle and a full pulse follows.
- Reset asserted while pwm_o=1 -> pwm_o=0 within the same cycle (asynchronous); after release, width_o=1500 and state is IDLE.
